bits_req_arbiter: RTL and testbench

Controller that shares one bit-stream extractor between NREQ requesters. The extractor has a 32-bit word push side, a 4-bit length request side, a 1024-bit circular buffer and 2-cycle response latency.
- Meters upstream words into the extractor.
- Tracks the buffered bit level.
- Grants at most one bit request per cycle, round-robin, and only when enough bits are buffered.
- Routes each extractor response back to the requester that issued it.

---
 rtl/bits_pkg.sv | 43 ++++
 rtl/bits_tag_pipe.sv | 34 +++
 rtl/bits_req_arbiter.sv | 153 +++++++++++++++
 tb/tb_bits_req_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bits_pkg.sv
// Shared types and helpers for the bit-request arbiter.
// With BITS_ARB_CHECK_EN defined the tag also carries the requested length.
package bits_pkg;

    localparam int WORD_W  = 32;
    localparam int LEN_W   = 4;
    localparam int DOUT_W  = 15;
    localparam int ID_W    = 3;
    localparam int MAX_REQ = 8;

    typedef struct packed {
        logic             valid;
        logic [ID_W-1:0]  id;
`ifdef BITS_ARB_CHECK_EN
        logic [LEN_W-1:0] len;
`endif
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

    // One-hot pick of the first set bit of req_mask at or after ptr, wrapping at nreq.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req_mask,
        input logic [ID_W-1:0]    ptr,
        input int                 nreq
    );
        logic [MAX_REQ-1:0] pick;
        logic               found;
        logic [ID_W:0]      idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = {1'b0, ptr} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(nreq)) idx = idx - (ID_W+1)'(nreq);
            if (k < nreq && !found && req_mask[idx[ID_W-1:0]]) begin
                pick[idx[ID_W-1:0]] = 1'b1;
                found               = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/bits_tag_pipe.sv
// LAT-deep shift register of grant tags; the tail stage lines up with the
// extractor response strobe of the current cycle.
module bits_tag_pipe
    import bits_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TAG_W-1:0] tag_in,
    output logic [TAG_W-1:0] tail
);

    logic [TAG_W-1:0] stage_q [LAT];
    logic [TAG_W-1:0] stage_d [LAT];

    always_comb begin
        stage_d[0] = tag_in;
        for (int i = 1; i < LAT; i++) stage_d[i] = stage_q[i-1];
    end

    // NOTE: this array is reset on purpose: a stale valid tag surviving reset would
    // pair with a later extractor strobe and route a response nobody asked for.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
        end else begin
            for (int i = 0; i < LAT; i++) stage_q[i] <= stage_d[i];
        end
    end

    assign tail = stage_q[LAT-1];

endmodule

// File: rtl/bits_req_arbiter.sv
// Shares one bit-stream extractor between NREQ requesters: word metering, level
// tracking, round-robin bit grants and response routing. BITS_ARB_CHECK_EN adds err.
module bits_req_arbiter
    import bits_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int LAT      = 2,
    parameter int BUF_BITS = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          src_valid,
    input  logic [31:0]                   src_data,
    output logic                          src_ready,
    output logic                          ext_pushin,
    output logic [31:0]                   ext_datain,
    output logic                          ext_reqin,
    output logic [3:0]                    ext_reqlen,
    input  logic                          ext_pushout,
    input  logic [3:0]                    ext_lenout,
    input  logic [14:0]                   ext_dataout,
    input  logic [NREQ-1:0]               req,
    input  logic [4*NREQ-1:0]             req_len,
    output logic [NREQ-1:0]               gnt,
    output logic [NREQ-1:0]               rsp_valid,
    output logic [3:0]                    rsp_len,
    output logic [14:0]                   rsp_data,
    output logic [$clog2(BUF_BITS+1)-1:0] level
`ifdef BITS_ARB_CHECK_EN
    ,
    output logic                          err
`endif
);

    localparam int               LVL_W    = $clog2(BUF_BITS + 1);
    localparam logic [LVL_W-1:0] PUSH_MAX = LVL_W'(BUF_BITS - WORD_W);

    logic [LVL_W-1:0]   level_q, level_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [LEN_W-1:0]   rsp_len_q, rsp_len_d;
    logic [DOUT_W-1:0]  rsp_data_q, rsp_data_d;
    logic [NREQ-1:0]    eligible;
    logic [MAX_REQ-1:0] pick;
    logic [ID_W-1:0]    gnt_id;
    logic [LEN_W-1:0]   gnt_len;
    tag_t               tag_in, tail;

    // Reset also gates the combinational outputs so everything reads 0 while rst is low.
    assign src_ready  = rst && (level_q <= PUSH_MAX);
    assign ext_pushin = src_valid && src_ready;
    assign ext_datain = src_data;

    // NOTE: every comb output gets a default before any conditional update; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NREQ; i++)
            eligible[i] = rst && req[i] && (LVL_W'(req_len[i*LEN_W +: LEN_W]) <= level_q);
        pick    = rr_pick(MAX_REQ'(eligible), ptr_q, NREQ);
        gnt_id  = '0;
        gnt_len = '0;
        for (int i = 0; i < MAX_REQ; i++)
            if (pick[i]) gnt_id = ID_W'(i);
        for (int i = 0; i < NREQ; i++)
            if (pick[i]) gnt_len = req_len[i*LEN_W +: LEN_W];
    end

    assign gnt        = pick[NREQ-1:0];
    assign ext_reqin  = |gnt;
    assign ext_reqlen = gnt_len;

    always_comb begin
        level_d = level_q + (ext_pushin ? LVL_W'(WORD_W) : '0)
                          - (ext_reqin ? LVL_W'(ext_reqlen) : '0);
        ptr_d = ptr_q;
        if (ext_reqin) ptr_d = (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + ID_W'(1);

        tag_in       = '0;
        tag_in.valid = ext_reqin;
        tag_in.id    = gnt_id;
`ifdef BITS_ARB_CHECK_EN
        tag_in.len   = ext_reqlen;
`endif

        rsp_valid_d = '0;
        for (int i = 0; i < NREQ; i++)
            rsp_valid_d[i] = ext_pushout && tail.valid && (tail.id == ID_W'(i));
        rsp_len_d  = rsp_len_q;
        rsp_data_d = rsp_data_q;
        if (ext_pushout && tail.valid) begin
            rsp_len_d  = ext_lenout;
            rsp_data_d = ext_dataout;
        end
    end

    bits_tag_pipe #(.LAT(LAT)) u_tag_pipe (
        .clk    (clk),
        .rst    (rst),
        .tag_in (tag_in),
        .tail   (tail)
    );

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q     <= '0;
            ptr_q       <= '0;
            rsp_valid_q <= '0;
            rsp_len_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            level_q     <= level_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_len_q   <= rsp_len_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign level     = level_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_len   = rsp_len_q;
    assign rsp_data  = rsp_data_q;

`ifdef BITS_ARB_CHECK_EN
    logic            err_q, err_d;
    logic [NREQ-1:0] waiting_q, waiting_d;

    // A requester left eligible but ungranted last cycle must still be requesting now.
    always_comb begin
        waiting_d = eligible & ~gnt;
        err_d     = err_q
                  | (ext_pushout != tail.valid)
                  | (ext_pushout && tail.valid && (ext_lenout != tail.len))
                  | (|(waiting_q & ~req));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q     <= 1'b0;
            waiting_q <= '0;
        end else begin
            err_q     <= err_d;
            waiting_q <= waiting_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_bits_req_arbiter.sv
// Directed bench for bits_req_arbiter with a 2-cycle extractor model whose
// response data is 0x5500 | len.
module tb_bits_req_arbiter;

    localparam int NREQ = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        src_valid;
    logic [31:0] src_data;
    logic        src_ready;
    logic        ext_pushin;
    logic [31:0] ext_datain;
    logic        ext_reqin;
    logic [3:0]  ext_reqlen;
    logic        ext_pushout;
    logic [3:0]  ext_lenout;
    logic [14:0] ext_dataout;
    logic [NREQ-1:0]   req;
    logic [4*NREQ-1:0] req_len;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [3:0]        rsp_len;
    logic [14:0]       rsp_data;
    logic [10:0]       level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bits_req_arbiter #(.NREQ(NREQ), .LAT(2), .BUF_BITS(1024)) dut (
        .clk         (clk),
        .rst         (rst),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_ready   (src_ready),
        .ext_pushin  (ext_pushin),
        .ext_datain  (ext_datain),
        .ext_reqin   (ext_reqin),
        .ext_reqlen  (ext_reqlen),
        .ext_pushout (ext_pushout),
        .ext_lenout  (ext_lenout),
        .ext_dataout (ext_dataout),
        .req         (req),
        .req_len     (req_len),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .rsp_len     (rsp_len),
        .rsp_data    (rsp_data),
        .level       (level)
    );

    // Extractor model: not reset by rst, like a separate block would behave.
    logic       e1_v = 1'b0, e2_v = 1'b0;
    logic [3:0] e1_len = 4'd0, e2_len = 4'd0;

    always @(posedge clk) begin
        e1_v   <= ext_reqin;
        e1_len <= ext_reqlen;
        e2_v   <= e1_v;
        e2_len <= e1_len;
    end

    assign ext_pushout = e2_v;
    assign ext_lenout  = e2_v ? e2_len : 4'd0;
    assign ext_dataout = e2_v ? (15'h5500 | 15'(e2_len)) : 15'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] rr_exp [5];

    initial begin
        rr_exp    = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
        rst       = 1'b0;
        src_valid = 1'b0;
        src_data  = '0;
        req       = 4'b0001;
        req_len   = '0;
        repeat (2) cyc();
        #1;
        chk("rst_level",     32'(level),      32'd0);
        chk("rst_gnt",       32'(gnt),        32'd0);
        chk("rst_reqin",     32'(ext_reqin),  32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid),  32'd0);
        chk("rst_rsp_len",   32'(rsp_len),    32'd0);
        chk("rst_rsp_data",  32'(rsp_data),   32'd0);
        chk("rst_src_ready", 32'(src_ready),  32'd0);

        // Two pushes from empty
        req = '0;
        cyc();
        rst       = 1'b1;
        src_valid = 1'b1;
        src_data  = 32'hFFFF0000;
        #1;
        chk("push1_ready",  32'(src_ready),  32'd1);
        chk("push1_pushin", 32'(ext_pushin), 32'd1);
        chk("push1_datain", ext_datain,      32'hFFFF0000);
        chk("push1_gnt",    32'(gnt),        32'd0);
        cyc();
        chk("lvl_32", 32'(level), 32'd32);
        src_data = 32'h0000FFFF;
        #1;
        chk("push2_ready",  32'(src_ready), 32'd1);
        chk("push2_datain", ext_datain,     32'h0000FFFF);
        cyc();
        src_valid = 1'b0;
        #1;
        chk("lvl_64",   32'(level), 32'd64);
        chk("gnt_idle", 32'(gnt),   32'd0);

        // Requester 0, len 5, three back-to-back grants
        req     = 4'b0001;
        req_len = 16'h0005;
        #1;
        chk("gnt_a",    32'(gnt),        32'h1);
        chk("reqlen_a", 32'(ext_reqlen), 32'd5);
        cyc();
        chk("lvl_59", 32'(level), 32'd59);
        chk("gnt_b",  32'(gnt),   32'h1);
        cyc();
        chk("lvl_54",     32'(level),     32'd54);
        chk("rsp_not_yet", 32'(rsp_valid), 32'd0);
        cyc();
        req = '0;
        #1;
        chk("lvl_49",     32'(level),     32'd49);
        chk("gnt_off",    32'(gnt),       32'd0);
        chk("rsp_a",      32'(rsp_valid), 32'h1);
        chk("rsp_a_len",  32'(rsp_len),   32'd5);
        chk("rsp_a_data", 32'(rsp_data),  32'h5505);
        cyc();
        chk("rsp_b", 32'(rsp_valid), 32'h1);
        cyc();
        chk("rsp_c", 32'(rsp_valid), 32'h1);
        cyc();
        chk("rsp_done",     32'(rsp_valid), 32'd0);
        chk("rsp_len_hold", 32'(rsp_len),   32'd5);

        // Drain to 4 with three len-15 grants
        req     = 4'b0001;
        req_len = 16'h000F;
        repeat (3) cyc();
        req = '0;
        #1;
        chk("lvl_4", 32'(level), 32'd4);

        // Only requester 2 fits at level 4; requester 1 after the push
        req       = 4'b0110;
        req_len   = 16'h0380;
        src_valid = 1'b1;
        src_data  = 32'h12345678;
        #1;
        chk("gnt_fit_r2",    32'(gnt),        32'h4);
        chk("reqlen_fit_r2", 32'(ext_reqlen), 32'd3);
        cyc();
        req       = 4'b0010;
        src_valid = 1'b0;
        #1;
        chk("lvl_33",    32'(level),      32'd33);
        chk("gnt_r1",    32'(gnt),        32'h2);
        chk("reqlen_r1", 32'(ext_reqlen), 32'd8);
        cyc();
        req = '0;
        #1;
        chk("lvl_25", 32'(level), 32'd25);

        // Reach level 100 with pointer 0 via two grants to requester 3
        req       = 4'b1000;
        req_len   = 16'hF000;
        src_valid = 1'b1;
        #1;
        chk("gnt_r3", 32'(gnt), 32'h8);
        cyc();
        req_len = 16'h6000;
        cyc();
        req = '0;
        cyc();
        src_valid = 1'b0;
        #1;
        chk("lvl_100", 32'(level), 32'd100);

        // All four requesting len 1: rotation 0,1,2,3,0
        req     = 4'hF;
        req_len = 16'h1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_order", 32'(gnt), 32'(rr_exp[k]));
            cyc();
        end
        req = '0;
        #1;
        chk("lvl_95", 32'(level), 32'd95);

        // Fill to 1000: 29 pushes, first two alongside len-15 and len-8 grants
        for (int k = 0; k < 29; k++) begin
            src_valid = 1'b1;
            src_data  = 32'(k);
            req       = (k < 2) ? 4'b0001 : 4'b0000;
            req_len   = (k == 0) ? 16'h000F : 16'h0008;
            #1;
            chk("fill_ready", 32'(src_ready), 32'd1);
            cyc();
        end
        req = '0;
        #1;
        chk("lvl_1000",    32'(level),      32'd1000);
        chk("full_ready",  32'(src_ready),  32'd0);
        chk("full_pushin", 32'(ext_pushin), 32'd0);
        req     = 4'b0010;
        req_len = 16'h00F0;
        #1;
        chk("gnt_full", 32'(gnt), 32'h2);
        cyc();
        req     = 4'b0100;
        req_len = 16'h0A00;
        #1;
        chk("lvl_985",     32'(level),      32'd985);
        chk("ready_985",   32'(src_ready),  32'd1);
        chk("pushin_985",  32'(ext_pushin), 32'd1);
        chk("gnt_985",     32'(gnt),        32'h4);
        cyc();
        req       = '0;
        src_valid = 1'b0;
        #1;
        chk("lvl_1007",   32'(level),     32'd1007);
        chk("ready_1007", 32'(src_ready), 32'd0);

        // Fresh reset, then a len-0 request at level 0
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        rst     = 1'b1;
        req     = 4'b1000;
        req_len = 16'h0000;
        #1;
        chk("len0_lvl",    32'(level),      32'd0);
        chk("len0_gnt",    32'(gnt),        32'h8);
        chk("len0_reqin",  32'(ext_reqin),  32'd1);
        chk("len0_reqlen", 32'(ext_reqlen), 32'd0);
        cyc();
        req = '0;
        #1;
        chk("len0_lvl_after", 32'(level),     32'd0);
        chk("len0_rsp_early", 32'(rsp_valid), 32'd0);
        cyc();
        chk("len0_rsp_early2", 32'(rsp_valid), 32'd0);
        cyc();
        chk("len0_rsp",      32'(rsp_valid), 32'h8);
        chk("len0_rsp_len",  32'(rsp_len),   32'd0);
        chk("len0_rsp_data", 32'(rsp_data),  32'h5500);

        // Reset while a tag is in flight: its response must be dropped
        req = 4'b0001;
        #1;
        chk("midrst_gnt", 32'(gnt), 32'h1);
        cyc();
        rst       = 1'b0;
        src_valid = 1'b1;
        #1;
        chk("midrst_level",     32'(level),      32'd0);
        chk("midrst_gnt_off",   32'(gnt),        32'd0);
        chk("midrst_reqin",     32'(ext_reqin),  32'd0);
        chk("midrst_reqlen",    32'(ext_reqlen), 32'd0);
        chk("midrst_pushin",    32'(ext_pushin), 32'd0);
        chk("midrst_ready",     32'(src_ready),  32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid),  32'd0);
        chk("midrst_rsp_len",   32'(rsp_len),    32'd0);
        chk("midrst_rsp_data",  32'(rsp_data),   32'd0);
        cyc();
        rst       = 1'b1;
        req       = '0;
        src_valid = 1'b0;
        #1;
        chk("midrst_rsp_h2", 32'(rsp_valid), 32'd0);
        cyc();
        chk("midrst_rsp_h3",  32'(rsp_valid), 32'd0);
        chk("midrst_data_h3", 32'(rsp_data),  32'd0);
        cyc();
        chk("midrst_rsp_h4", 32'(rsp_valid), 32'd0);
        chk("midrst_lvl_h4", 32'(level),     32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
